// File: rtl/riscv_muldiv.sv
// RV32M execute unit: pipelined multiplier and radix-2 restoring divider
// sharing a single valid/ready issue port, with hold and flush.
module riscv_muldiv #(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic            clk,
  input  logic            srst_n,
  input  logic            valid,
  input  logic [31:0]     opcode,
  input  logic [XLEN-1:0] ra,
  input  logic [XLEN-1:0] rb,
  input  logic            hold,
  input  logic            flush,
  output logic            ready,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  localparam int NS = MUL_LATENCY - 1;
  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [31:0] INST_MUL_MASK = 32'hFE00707F;
  localparam logic [31:0] INST_MUL      = 32'h02000033;
  localparam logic [31:0] INST_MULH     = 32'h02001033;
  localparam logic [31:0] INST_MULHSU   = 32'h02002033;
  localparam logic [31:0] INST_MULHU    = 32'h02003033;
  localparam logic [31:0] INST_DIV      = 32'h02004033;
  localparam logic [31:0] INST_DIVU     = 32'h02005033;
  localparam logic [31:0] INST_REM      = 32'h02006033;
  localparam logic [31:0] INST_REMU     = 32'h02007033;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [31:0] op_m;
  logic m_mul, m_mulh, m_mulhsu, m_mulhu;
  logic m_div, m_divu, m_rem, m_remu;
  logic is_mul, is_div, d_sgn, d_rem;

  assign op_m     = opcode & INST_MUL_MASK;
  assign m_mul    = op_m == INST_MUL;
  assign m_mulh   = op_m == INST_MULH;
  assign m_mulhsu = op_m == INST_MULHSU;
  assign m_mulhu  = op_m == INST_MULHU;
  assign m_div    = op_m == INST_DIV;
  assign m_divu   = op_m == INST_DIVU;
  assign m_rem    = op_m == INST_REM;
  assign m_remu   = op_m == INST_REMU;
  assign is_mul   = m_mul | m_mulh | m_mulhsu | m_mulhu;
  assign is_div   = m_div | m_divu | m_rem | m_remu;
  assign d_sgn    = m_div | m_rem;
  assign d_rem    = m_rem | m_remu;

  logic [1:0]      state_q;
  logic [NS-1:0]   mv_q;
  logic [XLEN-1:0] md_q [NS];
  logic [XLEN-1:0] quo_q, rem_q, dvs_q, res_q;
  logic [CW-1:0]   cnt_q;
  logic            qneg_q, rneg_q, isrem_q, rv_q;

  logic acc, acc_mul, acc_div;

  assign ready   = (state_q == S_IDLE) & ~(is_div & (|mv_q));
  assign acc     = valid & ready & ~hold & ~flush;
  assign acc_mul = acc & is_mul;
  assign acc_div = acc & is_div;

  // Both operands widened by one bit so one signed multiply covers all forms.
  logic signed [XLEN:0]     ma, mb;
  logic signed [2*XLEN-1:0] prod;
  logic [XLEN-1:0]          mul_res;

  assign ma      = {(m_mulh | m_mulhsu) & ra[XLEN-1], ra};
  assign mb      = {m_mulh & rb[XLEN-1], rb};
  assign prod    = ma * mb;
  assign mul_res = m_mul ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  logic            a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_abs, b_abs;

  assign a_neg    = d_sgn & ra[XLEN-1];
  assign b_neg    = d_sgn & rb[XLEN-1];
  assign a_abs    = a_neg ? -ra : ra;
  assign b_abs    = b_neg ? -rb : rb;
  assign div_zero = rb == '0;
  assign div_ovf  = d_sgn & (ra == {1'b1, {(XLEN-1){1'b0}}}) & (rb == '1);

  logic [XLEN:0]   sh, diff;
  logic [XLEN-1:0] quo_d, rem_d, fix_res;

  assign sh      = {rem_q, quo_q[XLEN-1]};
  assign diff    = sh - {1'b0, dvs_q};
  assign quo_d   = {quo_q[XLEN-2:0], ~diff[XLEN]};
  assign rem_d   = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
  assign fix_res = isrem_q ? (rneg_q ? -rem_q : rem_q)
                           : (qneg_q ? -quo_q : quo_q);

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state_q <= S_IDLE;
      mv_q    <= '0;
      for (int i = 0; i < NS; i++) md_q[i] <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      isrem_q <= 1'b0;
      rv_q    <= 1'b0;
      res_q   <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
      mv_q    <= '0;
      rv_q    <= 1'b0;
    end else if (!hold) begin
      mv_q[0] <= acc_mul;
      md_q[0] <= mul_res;
      for (int i = 1; i < NS; i++) begin
        mv_q[i] <= mv_q[i-1];
        md_q[i] <= md_q[i-1];
      end
      rv_q <= 1'b0;
      if (mv_q[NS-1]) begin
        rv_q  <= 1'b1;
        res_q <= md_q[NS-1];
      end else if (state_q == S_FIX) begin
        rv_q  <= 1'b1;
        res_q <= fix_res;
      end
      unique case (state_q)
        S_IDLE: begin
          if (acc_div) begin
            isrem_q <= d_rem;
            unique case (1'b1)
              div_zero: begin
                quo_q   <= '1;
                rem_q   <= ra;
                qneg_q  <= 1'b0;
                rneg_q  <= 1'b0;
                state_q <= S_FIX;
              end
              div_ovf: begin
                quo_q   <= ra;
                rem_q   <= '0;
                qneg_q  <= 1'b0;
                rneg_q  <= 1'b0;
                state_q <= S_FIX;
              end
              default: begin
                quo_q   <= a_abs;
                rem_q   <= '0;
                dvs_q   <= b_abs;
                qneg_q  <= a_neg ^ b_neg;
                rneg_q  <= a_neg;
                cnt_q   <= CW'(XLEN - 1);
                state_q <= S_RUN;
              end
            endcase
          end
        end
        S_RUN: begin
          quo_q <= quo_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) state_q <= S_FIX;
        end
        S_FIX:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign result_valid = rv_q;
  assign result       = res_q;

endmodule
